// File: rtl/bus_arbiter_2m_if.sv
// bus_arbiter_2m_if: memory bus request/response bundle with master and slave views
interface bus_arbiter_2m_if #(parameter int ADDR_W = 32, parameter int DATA_W = 32);
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] rdata;
  logic valid;
  logic mode;
  logic rready;
  logic wready;
  logic rvalid;
  modport master(output addr, wdata, valid, mode, rready, input wready, rvalid, rdata);
  modport slave(input addr, wdata, valid, mode, rready, output wready, rvalid, rdata);
endinterface

// File: rtl/bus_arbiter_2m.sv
// bus_arbiter_2m: round-robin two-master to one-slave bus arbiter with transaction watchdog
module bus_arbiter_2m #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic                   clk,
  input  logic                   rst,
  bus_arbiter_2m_if.slave        m0,
  bus_arbiter_2m_if.slave        m1,
  bus_arbiter_2m_if.master       s,
  output logic                   m0_err,
  output logic                   m1_err,
  output logic [1:0]             grant
);
  typedef enum logic [1:0] {IDLE, G0, G1, ERR} state_t;
  state_t     state;
  logic       last;
  logic [1:0] err;
  logic       sel0, sel1, done, to;
  assign sel0     = state == G0;
  assign sel1     = state == G1;
  assign s.valid  = (sel0 & m0.valid) | (sel1 & m1.valid);
  assign s.mode   = (sel0 & m0.mode) | (sel1 & m1.mode);
  assign s.rready = (sel0 & m0.rready) | (sel1 & m1.rready);
  assign s.addr   = sel0 ? m0.addr : sel1 ? m1.addr : {ADDR_W{1'b0}};
  assign s.wdata  = sel0 ? m0.wdata : sel1 ? m1.wdata : {DATA_W{1'b0}};
  assign done     = s.valid & (s.mode ? s.wready : s.rvalid & s.rready);
  assign m0.wready = sel0 & s.valid & s.mode & s.wready;
  assign m1.wready = sel1 & s.valid & s.mode & s.wready;
  assign m0.rvalid = sel0 & s.valid & ~s.mode & s.rvalid;
  assign m1.rvalid = sel1 & s.valid & ~s.mode & s.rvalid;
  assign m0.rdata  = s.rdata;
  assign m1.rdata  = s.rdata;
  assign m0_err    = err[0];
  assign m1_err    = err[1];
  // last = 1 means M1 was served most recently, so M0 wins the next tie
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      grant <= 2'b00;
      last  <= 1'b1;
      err   <= 2'b00;
    end else begin
      err <= 2'b00;
      case (state)
        IDLE:
          if (m0.valid && (!m1.valid || last)) begin
            state <= G0;
            grant <= 2'b01;
          end else if (m1.valid) begin
            state <= G1;
            grant <= 2'b10;
          end
        G0, G1:
          if (!s.valid || done) begin
            state <= IDLE;
            grant <= 2'b00;
            last  <= sel1;
          end else if (to) begin
            state <= ERR;
            grant <= 2'b00;
            err   <= grant;
          end
        default: begin
          state <= IDLE;
          last  <= err[1];
        end
      endcase
    end
  generate
    if (TIMEOUT > 0) begin : g_wd
      localparam int CW = $clog2(TIMEOUT + 1);
      logic [CW-1:0] cnt;
      always_ff @(posedge clk or posedge rst)
        if (rst) cnt <= '0;
        else cnt <= (sel0 | sel1) ? cnt + CW'(1) : '0;
      assign to = (cnt == CW'(TIMEOUT - 1)) && !done;
    end else begin : g_nowd
      assign to = 1'b0;
    end
  endgenerate
endmodule
